// File: rtl/key_deserializer.sv
// -----------------------------------------------------------------------------
// key_deserializer
//
// Builds WIDTH-bit words from two push-button style inputs. A rising edge on
// key1 enters a 1 and a rising edge on key2 enters a 0. A rising edge on start
// opens (or restarts) a frame. All three raw inputs are asynchronous and are
// synchronized before edge detection.
//
// Ports
//   clk        : single rising-edge clock
//   rst        : synchronous, active-high reset
//   start      : raw async level, rising edge arms / restarts a frame
//   key1       : raw async level, rising edge enters bit 1
//   key2       : raw async level, rising edge enters bit 0
//   data_out   : last completed word, held between frames
//   data_valid : one-cycle pulse when data_out is loaded
//   busy       : registered decode of state == SHIFT
//   bit_count  : bits accepted in the current frame
//   collision  : one-cycle pulse when key1 and key2 edges coincide in SHIFT
// -----------------------------------------------------------------------------
module key_deserializer #(
  parameter int WIDTH       = 4,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CONTINUOUS  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         key1,
  input  logic                         key2,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         collision
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizer chains, edge history and arming flags.
  logic [SYNC_STAGES-1:0] sync_start_q, sync_key1_q, sync_key2_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [2:0]             prev_q;
  logic [2:0]             arm_q;
  logic [2:0]             sync_last;
  logic [2:0]             edge_det;

  // Datapath and control registers.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             col_q, col_d;
  logic             busy_q;
  logic [WIDTH-1:0] shifted;
  logic             start_e, key1_e, key2_e;

  assign sync_last = {sync_key2_q[SYNC_STAGES-1], sync_key1_q[SYNC_STAGES-1],
                      sync_start_q[SYNC_STAGES-1]};

  // An input only becomes armed once a genuine post-reset low sample has
  // reached the end of its chain (fill_q marks which stages hold real samples).
  // This keeps a level held high through reset release from looking like an
  // edge when the cleared chain refills with ones.
  assign edge_det = sync_last & ~prev_q & arm_q;
  assign start_e  = edge_det[0];
  assign key1_e   = edge_det[1];
  assign key2_e   = edge_det[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_start_q <= '0;
      sync_key1_q  <= '0;
      sync_key2_q  <= '0;
      fill_q       <= '0;
      prev_q       <= '0;
      arm_q        <= '0;
    end else begin
      sync_start_q <= {sync_start_q[SYNC_STAGES-2:0], start};
      sync_key1_q  <= {sync_key1_q[SYNC_STAGES-2:0], key1};
      sync_key2_q  <= {sync_key2_q[SYNC_STAGES-2:0], key2};
      fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q       <= sync_last;
      arm_q        <= arm_q | ({3{fill_q[SYNC_STAGES-1]}} & ~sync_last);
    end
  end

  // Candidate shift-register value with key1 as the incoming bit; only used
  // when exactly one key edge is present, so key1_e alone selects the bit.
  always_comb begin
    shifted = '0;
    if (LSB_FIRST != 0) begin
      shifted = {key1_e, sr_q[WIDTH-1:1]};
    end else begin
      shifted = {sr_q[WIDTH-2:0], key1_e};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    col_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d = SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Start outranks any key edge in the same cycle.
        if (start_e) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (key1_e && key2_e) begin
          col_d = 1'b1;
        end else if (key1_e || key2_e) begin
          if (cnt_q == CW'(WIDTH-1)) begin
            dout_d  = shifted;
            dv_d    = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
            state_d = (CONTINUOUS != 0) ? SHIFT : IDLE;
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      col_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      col_q   <= col_d;
      busy_q  <= (state_d == SHIFT);
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;
  assign bit_count  = cnt_q;
  assign collision  = col_q;

endmodule

// File: tb/tb_key_deserializer.sv
module tb_key_deserializer;

  localparam int GAP = 7;  // low time after each pulse, covers the longest chain

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, key1 = 1'b0, key2 = 1'b0;

  logic [3:0] dout [3];
  logic       dv   [3];
  logic       busy [3];
  logic [2:0] bc   [3];
  logic       col  [3];

  always #5 clk = ~clk;

  // dut0: LSB first, one-shot. dut1: MSB first, one-shot, 3 sync stages.
  // dut2: LSB first, continuous.
  key_deserializer #(.WIDTH(4), .LSB_FIRST(1), .SYNC_STAGES(2), .CONTINUOUS(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .key1(key1), .key2(key2),
    .data_out(dout[0]), .data_valid(dv[0]), .busy(busy[0]), .bit_count(bc[0]),
    .collision(col[0]));
  key_deserializer #(.WIDTH(4), .LSB_FIRST(0), .SYNC_STAGES(3), .CONTINUOUS(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .key1(key1), .key2(key2),
    .data_out(dout[1]), .data_valid(dv[1]), .busy(busy[1]), .bit_count(bc[1]),
    .collision(col[1]));
  key_deserializer #(.WIDTH(4), .LSB_FIRST(1), .SYNC_STAGES(2), .CONTINUOUS(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .key1(key1), .key2(key2),
    .data_out(dout[2]), .data_valid(dv[2]), .busy(busy[2]), .bit_count(bc[2]),
    .collision(col[2]));

  int checks = 0;
  int errors = 0;

  // Behavioural model: per DUT, whether a frame is open, the bits collected so
  // far, and the number of collisions expected.
  int         mact [3];
  int         mcnt [3];
  logic [3:0] macc [3];
  int         mcoll[3];
  int         coll_seen[3];

  logic [3:0] q0[$], q1[$], q2[$];

  function automatic bit is_lsb(int d);  return d != 1; endfunction
  function automatic bit is_cont(int d); return d == 2; endfunction

  task automatic push(input int d, input logic [3:0] w);
    case (d)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic pop(input int d, output bit ok, output logic [3:0] w);
    ok = 1'b0; w = '0;
    case (d)
      0: if (q0.size() > 0) begin w = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin w = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin w = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", nm, d, act, exp);
    end
  endtask

  // Model events.
  task automatic m_start();
    for (int d = 0; d < 3; d++) begin
      mact[d] = 1; mcnt[d] = 0; macc[d] = '0;
    end
  endtask

  task automatic m_bit(input bit b);
    for (int d = 0; d < 3; d++) begin
      if (mact[d] != 0) begin
        macc[d][is_lsb(d) ? mcnt[d] : 3 - mcnt[d]] = b;
        mcnt[d]++;
        if (mcnt[d] == 4) begin
          push(d, macc[d]);
          mcnt[d] = 0; macc[d] = '0;
          if (!is_cont(d)) mact[d] = 0;
        end
      end
    end
  endtask

  task automatic m_coll();
    for (int d = 0; d < 3; d++) if (mact[d] != 0) mcoll[d]++;
  endtask

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      mact[d] = 0; mcnt[d] = 0; macc[d] = '0;
    end
  endtask

  // Monitor: pops an expected word on every data_valid, and watches the
  // output invariants every cycle.
  logic [3:0] prev_dout [3];
  logic       prev_dv   [3];
  initial for (int d = 0; d < 3; d++) begin prev_dout[d] = '0; prev_dv[d] = 1'b0; end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        if (dv[d]) begin
          bit ok; logic [3:0] w;
          checks++;
          pop(d, ok, w);
          if (!ok) begin
            errors++;
            $display("FAIL dv_unexpected dut%0d: data_out=%h with no word expected", d, dout[d]);
          end else if (dout[d] !== w) begin
            errors++;
            $display("FAIL data_out dut%0d: got %h, expected %h", d, dout[d], w);
          end
        end
        checks++;
        if ((dout[d] !== prev_dout[d] && !dv[d]) || (dv[d] && prev_dv[d]) || bc[d] > 3'd3) begin
          errors++;
          $display("FAIL invariant dut%0d: data_out %h->%h dv %b->%b bit_count %0d",
                   d, prev_dout[d], dout[d], prev_dv[d], dv[d], bc[d]);
        end
        if (col[d]) coll_seen[d]++;
      end
      prev_dout[d] = dout[d];
      prev_dv[d]   = dv[d];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input bit s, input bit k1, input bit k2);
    start = s; key1 = k1; key2 = k2;
    tick(2);
    start = 1'b0; key1 = 1'b0; key2 = 1'b0;
    tick(GAP);
  endtask

  task automatic check_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_busy"}, d, busy[d], mact[d]);
      chk({tag, "_bit_count"}, d, bc[d], mcnt[d]);
      chk({tag, "_collisions"}, d, coll_seen[d], mcoll[d]);
    end
  endtask

  task automatic do_start();       m_start();  pulse(1, 0, 0); check_state("start");     endtask
  task automatic do_startkey();    m_start();  pulse(1, 1, 0); check_state("start_key"); endtask
  task automatic do_bit(input bit b); m_bit(b); pulse(0, b, !b); check_state("bit");     endtask
  task automatic do_coll();        m_coll();   pulse(0, 1, 1); check_state("collision"); endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    tick(2);
    for (int d = 0; d < 3; d++) begin
      chk("rst_data_out", d, dout[d], 0);
      chk("rst_data_valid", d, dv[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_bit_count", d, bc[d], 0);
      chk("rst_collision", d, col[d], 0);
    end
    rst = 1'b0;
    tick(GAP);
  endtask

  task automatic bits4(input bit a, input bit b, input bit c, input bit e);
    do_bit(a); do_bit(b); do_bit(c); do_bit(e);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      mcoll[d] = 0; coll_seen[d] = 0;
    end
    m_reset();
    tick(1);
    do_reset();

    // 1,0,1,1: LSB-first word D, MSB-first word B.
    do_start(); bits4(1, 0, 1, 1);
    // Partial frame aborted by a second start.
    do_start(); do_bit(1); do_bit(1);
    do_start(); bits4(0, 0, 0, 0);
    // Simultaneous key edges, then four ones.
    do_start(); do_coll(); bits4(1, 1, 1, 1);
    // Eight bits after one start: continuous mode yields 1 then E.
    do_start(); bits4(1, 0, 0, 0); bits4(0, 1, 1, 1);
    // Start coincident with a key edge: the key is dropped.
    do_start(); do_bit(1); do_startkey(); bits4(0, 1, 0, 1);
    // Reset mid-frame, then keys without a start.
    do_start(); do_bit(1); do_bit(0); do_bit(1);
    do_reset();
    bits4(1, 1, 1, 1);
    // key1 held high through reset release gives no edge.
    do_start();
    m_bit(1); key1 = 1'b1; tick(GAP); check_state("held_key");
    do_reset();
    m_start(); start = 1'b1; tick(2); start = 1'b0; tick(GAP);
    check_state("held_after_rst");
    key1 = 1'b0; tick(GAP);
    check_state("held_released");
    bits4(0, 1, 1, 0);

    // Random event mix.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       do_start();
      else if (r < 11) do_startkey();
      else if (r < 16) do_coll();
      else if (r < 18) do_reset();
      else             do_bit(1'($urandom_range(0, 1)));
    end

    tick(5);
    for (int d = 0; d < 3; d++) chk("words_outstanding", d, qsize(d), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_deserializer.md
KEY_DESERIALIZER -- requirements
Module: key_deserializer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the output word width in bits, legal range 2..32.
REQ-002 The block SHALL take parameter LSB_FIRST, default 1: 1 means the first bit received lands in data_out[0]; 0 means it lands in data_out[WIDTH-1].
REQ-003 The block SHALL take parameter SYNC_STAGES, default 2, as the synchronizer flop count per raw input, legal range 2..4.
REQ-004 The block SHALL take parameter CONTINUOUS, default 0: 1 means stay in SHIFT after a frame; 0 means return to IDLE.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: asynchronous raw level; its rising edge arms a frame.
REQ-008 The block SHALL have port key1, input, 1 bit: asynchronous raw level; its rising edge enters bit 1.
REQ-009 The block SHALL have port key2, input, 1 bit: asynchronous raw level; its rising edge enters bit 0.
REQ-010 The block SHALL have port data_out, output, WIDTH bits: the last completed word.
REQ-011 The block SHALL have port data_valid, output, 1 bit: a one-cycle pulse when data_out is updated.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in state SHIFT.
REQ-013 The block SHALL have port bit_count, output, $clog2(WIDTH+1) bits: the number of bits accepted in the current frame.
REQ-014 The block SHALL have port collision, output, 1 bit: a one-cycle pulse when key1 and key2 edges are detected in the same cycle.

Function
REQ-015 Each of start, key1 and key2 SHALL pass through SYNC_STAGES flops, then a rising-edge detector: edge = sync AND NOT sync_prev.
REQ-016 Latency from a raw rising level, first sampled at clock edge N, to the detected edge pulse SHALL be SYNC_STAGES clocks; each detected pulse lasts exactly one cycle.
REQ-017 The state machine SHALL have exactly two states, IDLE and SHIFT.
REQ-018 IDLE -> SHIFT SHALL occur on a start edge, clearing the shift register and bit_count to 0.
REQ-019 In IDLE, key1 and key2 edges SHALL be ignored, with no effect on any output.
REQ-020 In SHIFT, an accepted bit (key1 edge -> 1, key2 edge -> 0) SHALL shift in as follows:
  - LSB_FIRST=1: sr <= {bit, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], bit}.
  - bit_count increments by 1.
REQ-021 When the accepted bit is the WIDTH-th bit (bit_count == WIDTH-1 before the edge), the same clock edge SHALL load data_out with the completed word and assert data_valid for exactly one cycle.
REQ-022 On that same edge, bit_count and the shift register SHALL clear to 0, and the state SHALL move to IDLE if CONTINUOUS=0 or remain in SHIFT if CONTINUOUS=1.
REQ-023 Simultaneous key1 and key2 edges in SHIFT SHALL accept no bit, SHALL pulse collision for one cycle, and SHALL leave bit_count and the shift register unchanged.
REQ-024 A start edge while in SHIFT SHALL abort the partial frame: the shift register and bit_count clear, the state stays SHIFT, and data_out and data_valid are unaffected.
REQ-025 A start edge coincident with a key edge SHALL give start priority: the frame restarts and the key edge is discarded.
REQ-026 data_out SHALL hold its value between frames and change only when data_valid is asserted.
REQ-027 busy SHALL be a registered decode of state == SHIFT; bit_count SHALL never exceed WIDTH-1 when observed.

Reset
REQ-028 With rst high at a clock edge, the following SHALL hold after that edge:
  - state = IDLE.
  - data_out = 0, data_valid = 0, busy = 0, bit_count = 0, collision = 0.
  - shift register = 0.
  - all synchronizer and edge-history flops = 0.
REQ-029 rst SHALL override all other inputs, including in the middle of a frame: the partial word is discarded and no data_valid is produced.
REQ-030 A key input held high through reset release SHALL NOT produce an edge until it goes low and then high again.

Verification
REQ-031 With WIDTH=4, LSB_FIRST=1, CONTINUOUS=0: a start pulse, then key edges 1,0,1,1 -> data_out = 4'hD, data_valid high for exactly 1 cycle, then busy = 0.
REQ-032 The same stimulus with LSB_FIRST=0 -> data_out = 4'hB; bit_count steps through 1,2,3 and then reads 0.
REQ-033 Start, key edges 1,1, then start again, then key edges 0,0,0,0 -> a single data_valid with data_out = 4'h0; the partial frame produces no output.
REQ-034 Start, key1 and key2 raised on the same clock, then key edges 1,1,1,1 -> collision pulses once, then data_out = 4'hF after exactly four accepted bits.
REQ-035 With CONTINUOUS=1: one start, then eight key edges 1,0,0,0,0,1,1,1 -> data_valid twice, with data_out = 4'h1 then 4'hE, and busy remains 1 throughout.
REQ-036 Reset asserted after 3 key edges -> all outputs 0; subsequent key edges without a new start give no data_valid.
